mist1032sa_async_fifo_write_ctrl: RTL

Write-domain controller of the asynchronous FIFO.
- Accepts write requests and drives the dual-port RAM write port.
- Maintains binary and Gray write pointers, and publishes the registered Gray write pointer to the read-domain two-stage synchronizer.
- Consumes the read pointer already synchronized into this domain, and produces full, almost-full, fill count and overflow status.

---
 rtl/mist1032sa_async_fifo_pkg.sv | 27 ++
 rtl/mist1032sa_async_fifo_write_ctrl_if.sv | 35 +++
 rtl/mist1032sa_async_fifo_gray_counter.sv | 42 ++++
 rtl/mist1032sa_async_fifo_write_ctrl.sv | 74 +++++++
 4 files changed

// File: rtl/mist1032sa_async_fifo_pkg.sv
// Shared helpers for the asynchronous FIFO write and read controllers.
//   DEPTH_N_DEF : default address width (FIFO depth = 2^DEPTH_N_DEF)
//   PTR_W       : pointer width for the default depth (one wrap bit on top)
//   bin2gray / gray2bin : pointer code conversions. They work on a 32-bit
//   carrier, so any pointer up to 32 bits wide is zero-extended in and the
//   result is cast back to the pointer width by the caller. Leading zeros
//   map to leading zeros in both directions, so the narrow result is exact.
package mist1032sa_async_fifo_pkg;

  localparam int DEPTH_N_DEF = 4;
  localparam int PTR_W       = DEPTH_N_DEF + 1;
  localparam int GRAY_MAX_W  = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/mist1032sa_async_fifo_write_ctrl_if.sv
// Write-side bus of the asynchronous FIFO.
// Handshake: iWR_REQ is a request qualified by the registered oWR_FULL,
// which acts as an inverted ready. A write is accepted in the cycle where
// iWR_REQ=1 and oWR_FULL=0; a request while full is dropped (and flagged as
// overflow), it is not held or retried by the controller.
//   master : producer / environment (drives request, data, synced read ptr)
//   slave  : write controller (drives status, Gray pointer and RAM port)
interface mist1032sa_async_fifo_write_ctrl_if #(
  parameter int D_N     = 32,
  parameter int DEPTH_N = 4
);
  logic               iWR_REQ;
  logic [D_N-1:0]     iWR_DATA;
  logic [DEPTH_N:0]   iRD_GRAY_PTR_SYNC;
  logic               oWR_FULL;
  logic               oWR_ALMOST_FULL;
  logic [DEPTH_N:0]   oWR_COUNT;
  logic               oWR_OVERFLOW;
  logic [DEPTH_N:0]   oWR_GRAY_PTR;
  logic               oMEM_WR_EN;
  logic [DEPTH_N-1:0] oMEM_WR_ADDR;
  logic [D_N-1:0]     oMEM_WR_DATA;

  modport master (
    output iWR_REQ, iWR_DATA, iRD_GRAY_PTR_SYNC,
    input  oWR_FULL, oWR_ALMOST_FULL, oWR_COUNT, oWR_OVERFLOW,
    input  oWR_GRAY_PTR, oMEM_WR_EN, oMEM_WR_ADDR, oMEM_WR_DATA
  );

  modport slave (
    input  iWR_REQ, iWR_DATA, iRD_GRAY_PTR_SYNC,
    output oWR_FULL, oWR_ALMOST_FULL, oWR_COUNT, oWR_OVERFLOW,
    output oWR_GRAY_PTR, oMEM_WR_EN, oMEM_WR_ADDR, oMEM_WR_DATA
  );
endinterface

// File: rtl/mist1032sa_async_fifo_gray_counter.sv
// Binary + Gray pointer pair for one side of the asynchronous FIFO.
//   iCLOCK, iRESET : clock, asynchronous active-high reset
//   iINC           : advance the pointer by one at the next edge
//   oGRAY          : registered Gray pointer, straight from a flop (CDC safe)
//   oADDR          : RAM address = low bits of the registered binary pointer
//   oBIN_NEXT      : binary pointer value after this cycle's increment
//   oGRAY_NEXT     : Gray code of oBIN_NEXT
module mist1032sa_async_fifo_gray_counter
  import mist1032sa_async_fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         iCLOCK,
  input  logic         iRESET,
  input  logic         iINC,
  output logic [W-1:0] oGRAY,
  output logic [W-2:0] oADDR,
  output logic [W-1:0] oBIN_NEXT,
  output logic [W-1:0] oGRAY_NEXT
);

  logic [W-1:0] bin_q;
  logic [W-1:0] gray_q;

  // Wraps modulo 2^W; the top bit distinguishes full from empty.
  assign oBIN_NEXT  = bin_q + W'(iINC);
  assign oGRAY_NEXT = W'(bin2gray(GRAY_MAX_W'(oBIN_NEXT)));

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= oBIN_NEXT;
      gray_q <= oGRAY_NEXT;
    end
  end

  assign oGRAY = gray_q;
  assign oADDR = bin_q[W-2:0];

endmodule

// File: rtl/mist1032sa_async_fifo_write_ctrl.sv
// Write-domain controller of the asynchronous FIFO.
//   iCLOCK, iRESET : write clock, asynchronous active-high reset
//   bus (slave)    : write request/data, synchronized read Gray pointer in;
//                    full / almost-full / count / overflow status, registered
//                    Gray write pointer and RAM write port out.
// Full and count are computed against the synchronized read pointer, so they
// lag real reads by the synchronizer latency: conservative, never optimistic.
module mist1032sa_async_fifo_write_ctrl
  import mist1032sa_async_fifo_pkg::*;
#(
  parameter int D_N      = 32,
  parameter int DEPTH_N  = DEPTH_N_DEF,
  parameter int AFULL_TH = 14
) (
  input  logic iCLOCK,
  input  logic iRESET,
  mist1032sa_async_fifo_write_ctrl_if.slave bus
);

  localparam int PW = DEPTH_N + 1;
  // Full when the write pointer equals the read pointer with its two top
  // Gray bits inverted (for DEPTH_N=1 that is both bits).
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic          push;
  logic [PW-1:0] gray_q;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] count_next;
  logic          full_q;
  logic          afull_q;
  logic [PW-1:0] count_q;
  logic          ovf_q;

  // Reset gating keeps the RAM port quiet while the pointer is being cleared.
  assign push = bus.iWR_REQ & ~full_q & ~iRESET;

  mist1032sa_async_fifo_gray_counter #(.W(PW)) u_wr_ptr (
    .iCLOCK     (iCLOCK),
    .iRESET     (iRESET),
    .iINC       (push),
    .oGRAY      (gray_q),
    .oADDR      (bus.oMEM_WR_ADDR),
    .oBIN_NEXT  (bin_next),
    .oGRAY_NEXT (gray_next)
  );

  assign rd_bin     = PW'(gray2bin(GRAY_MAX_W'(bus.iRD_GRAY_PTR_SYNC)));
  assign count_next = bin_next - rd_bin;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= (gray_next == (bus.iRD_GRAY_PTR_SYNC ^ FULL_MASK));
      afull_q <= (int'(count_next) >= AFULL_TH);
      count_q <= count_next;
      ovf_q   <= ovf_q | (bus.iWR_REQ & full_q);
    end
  end

  assign bus.oWR_FULL        = full_q;
  assign bus.oWR_ALMOST_FULL = afull_q;
  assign bus.oWR_COUNT       = count_q;
  assign bus.oWR_OVERFLOW    = ovf_q;
  assign bus.oWR_GRAY_PTR    = gray_q;
  assign bus.oMEM_WR_EN      = push;
  assign bus.oMEM_WR_DATA    = bus.iWR_DATA;

endmodule
